halut_decoder_stream: RTL and testbench

Streaming, back-pressured successor of the single-row HALUT decoder. Holds a C×K LUT of signed integer entries and accepts one prototype index (k) per beat. It sums the selected entries over a runtime-configurable number of codebooks and pushes each finished row sum into an output FIFO behind a valid/ready port. Sits between the encoder's k-index stream and the result collector; one instance per output column.

---
 rtl/halut_pkg.sv | 16 +
 rtl/halut_decoder_stream_if.sv | 26 ++
 rtl/halut_result_fifo.sv | 62 ++++++
 rtl/halut_decoder_stream.sv | 166 ++++++++++++++++
 tb/tb_halut_decoder_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/halut_pkg.sv
// Shared helpers and types for the streaming HALUT decoder.
// Row results travel as {sat, sum} pairs.
package halut_pkg;

  localparam int AccWidthDef = 32;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                          sat;
    logic signed [AccWidthDef-1:0] sum;
  } result_t;

endpackage

// File: rtl/halut_decoder_stream_if.sv
// k-index input stream and row-result output stream
// of the HALUT decoder.
interface halut_decoder_stream_if #(
  parameter int KAddrWidth = 4,
  parameter int AccWidth   = 32
);

  logic                       in_valid;
  logic                       in_ready;
  logic [KAddrWidth-1:0]      k_addr;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [AccWidth-1:0] result;
  logic                       sat;

  modport master (
    output in_valid, k_addr, out_ready,
    input  in_ready, out_valid, result, sat
  );

  modport slave (
    input  in_valid, k_addr, out_ready,
    output in_ready, out_valid, result, sat
  );

endinterface

// File: rtl/halut_result_fifo.sv
// Small flop-based FIFO holding finished row results.
// Head entry is presented directly on data_o.
module halut_result_fifo
  import halut_pkg::*;
#(
  parameter int  Depth = 2,
  parameter type T     = result_t,
  localparam int PtrWidth = addr_w(Depth),
  localparam int CntWidth = addr_w(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  T                    data_i,
  input  logic                pop_i,
  output T                    data_o,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  T                    mem_q [Depth];
  logic [PtrWidth-1:0] wr_q;
  logic [PtrWidth-1:0] rd_q;
  logic [CntWidth-1:0] cnt_q;
  logic                do_push;
  logic                do_pop;

  function automatic logic [PtrWidth-1:0] nxt(
    input logic [PtrWidth-1:0] p
  );
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      unique case (1'b1)
        do_push && !do_pop: cnt_q <= cnt_q + 1'b1;
        do_pop && !do_push: cnt_q <= cnt_q - 1'b1;
        default:            cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/halut_decoder_stream.sv
// Streaming HALUT row decoder: LUT lookup per k beat,
// row accumulation with overflow handling, result FIFO.
module halut_decoder_stream
  import halut_pkg::*;
#(
  parameter int  K             = 16,
  parameter int  C             = 32,
  parameter int  DataTypeWidth = 16,
  parameter int  AccWidth      = 32,
  parameter bit  Saturate      = 1'b1,
  parameter int  OutDepth      = 2,
  localparam int CAddrWidth     = addr_w(C),
  localparam int KAddrWidth     = addr_w(K),
  localparam int TotalAddrWidth = addr_w(C * K)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [TotalAddrWidth-1:0] waddr_i,
  input  logic [DataTypeWidth-1:0]  wdata_i,
  input  logic                      we_i,
  input  logic [CAddrWidth-1:0]     c_last_i,
  input  logic                      clear_i,
  halut_decoder_stream_if.slave     bus,
  output logic                      busy_o
);

  localparam int Entries  = C * K;
  localparam int CntWidth = addr_w(OutDepth + 1);

  typedef logic signed [DataTypeWidth-1:0] data_t;
  typedef logic signed [AccWidth-1:0]      acc_t;
  typedef struct packed {
    logic sat;
    acc_t sum;
  } row_res_t;

  localparam acc_t AccMax = {1'b0, {(AccWidth-1){1'b1}}};
  localparam acc_t AccMin = {1'b1, {(AccWidth-1){1'b0}}};

  data_t                     lut_q [Entries];
  logic [TotalAddrWidth-1:0] rd_addr;
  logic [CAddrWidth-1:0]     c_cnt;
  logic [CAddrWidth-1:0]     c_last_row;
  logic [CAddrWidth-1:0]     c_last_eff;
  logic                      in_ready;
  logic                      fire;
  logic                      first_beat;
  logic                      last_beat;

  logic                      s1_valid;
  logic                      s1_first;
  logic                      s1_last;
  data_t                     s1_entry;

  acc_t                      acc_q;
  logic                      flag_q;
  acc_t                      base;
  acc_t                      acc_d;
  logic signed [AccWidth:0]  wide;
  logic                      ovf;
  logic                      flag_d;

  logic                      push;
  logic                      pop;
  row_res_t                  push_data;
  row_res_t                  head;
  logic [CntWidth-1:0]       fifo_cnt;
  logic                      fifo_full;
  logic                      fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Entries; i++) lut_q[i] <= '0;
    end else if (we_i) begin
      lut_q[waddr_i] <= data_t'(wdata_i);
    end
  end

  assign rd_addr    = {c_cnt, bus.k_addr};
  assign fire       = bus.in_valid && in_ready && !clear_i;
  assign first_beat = (c_cnt == '0);
  // c_last_i only matters on the first beat of a row
  assign c_last_eff = first_beat ? c_last_i : c_last_row;
  assign last_beat  = (c_cnt == c_last_eff);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_cnt      <= '0;
      c_last_row <= '0;
    end else if (clear_i) begin
      c_cnt <= '0;
    end else if (fire) begin
      c_cnt <= last_beat ? '0 : c_cnt + 1'b1;
      if (first_beat) c_last_row <= c_last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_first <= first_beat;
        s1_last  <= last_beat;
        s1_entry <= lut_q[rd_addr];
      end
    end
  end

  always_comb begin
    base   = s1_first ? '0 : acc_q;
    wide   = (AccWidth+1)'(base) + (AccWidth+1)'(s1_entry);
    ovf    = wide[AccWidth] ^ wide[AccWidth-1];
    acc_d  = wide[AccWidth-1:0];
    if (Saturate && ovf) acc_d = wide[AccWidth] ? AccMin : AccMax;
    flag_d = (!s1_first && flag_q) || ovf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      flag_q <= 1'b0;
    end else if (clear_i || (s1_valid && s1_last)) begin
      acc_q  <= '0;
      flag_q <= 1'b0;
    end else if (s1_valid) begin
      acc_q  <= acc_d;
      flag_q <= flag_d;
    end
  end

  assign push      = s1_valid && s1_last && !clear_i && !fifo_full;
  assign push_data = '{sat: flag_d, sum: acc_d};
  assign pop       = bus.out_valid && bus.out_ready;

  halut_result_fifo #(
    .Depth (OutDepth),
    .T     (row_res_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // a pop in the same cycle earns no credit here
  assign in_ready =
    ((CntWidth+1)'(fifo_cnt) + (CntWidth+1)'(s1_valid && s1_last))
    < (CntWidth+1)'(OutDepth);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.result    = head.sum;
  assign bus.sat       = head.sat;
  assign busy_o        = (c_cnt != '0) || s1_valid;

endmodule

// File: tb/tb_halut_decoder_stream.sv
// Bench for halut_decoder_stream: three lockstep DUTs
// (32b sat, 16b sat, 16b wrap) against a row-sum model.
module tb_halut_decoder_stream;

  localparam int K  = 16;
  localparam int C  = 32;
  localparam int DW = 16;
  localparam int OD = 2;
  localparam int TA = 9;
  localparam int CA = 5;
  localparam int KA = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [TA-1:0]        waddr;
  logic signed [DW-1:0] wdata;
  logic                 we;
  logic [CA-1:0]        c_last;
  logic                 clear;
  logic                 busy_m, busy_s, busy_w;

  always #5 clk = ~clk;

  halut_decoder_stream_if #(.KAddrWidth(KA), .AccWidth(32)) bm ();
  halut_decoder_stream_if #(.KAddrWidth(KA), .AccWidth(16)) bs ();
  halut_decoder_stream_if #(.KAddrWidth(KA), .AccWidth(16)) bw ();

  assign bs.in_valid  = bm.in_valid;
  assign bs.k_addr    = bm.k_addr;
  assign bs.out_ready = bm.out_ready;
  assign bw.in_valid  = bm.in_valid;
  assign bw.k_addr    = bm.k_addr;
  assign bw.out_ready = bm.out_ready;

  halut_decoder_stream #(
    .K(K), .C(C), .DataTypeWidth(DW), .AccWidth(32),
    .Saturate(1'b1), .OutDepth(OD)
  ) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .c_last_i(c_last),
    .clear_i(clear), .bus(bm), .busy_o(busy_m)
  );

  halut_decoder_stream #(
    .K(K), .C(C), .DataTypeWidth(DW), .AccWidth(16),
    .Saturate(1'b1), .OutDepth(OD)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .c_last_i(c_last),
    .clear_i(clear), .bus(bs), .busy_o(busy_s)
  );

  halut_decoder_stream #(
    .K(K), .C(C), .DataTypeWidth(DW), .AccWidth(16),
    .Saturate(1'b0), .OutDepth(OD)
  ) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .c_last_i(c_last),
    .clear_i(clear), .bus(bw), .busy_o(busy_w)
  );

  typedef struct {
    longint v [3];
    bit     f [3];
  } res_t;

  typedef struct {
    int clast;
    int k [4];
    int sum;
  } vec_t;

  int     lut_m [C*K];
  res_t   exp_q [$];
  res_t   pend_r;
  bit     pend;
  bit     s1_occ;
  int     row_pos;
  int     row_len;
  longint acc [3];
  bit     flg [3];
  int     aw [3] = '{32, 16, 16};
  bit     sm [3] = '{1'b1, 1'b1, 1'b0};
  int     n_chk = 0;
  int     n_fail = 0;
  vec_t   tbl [6];

  task automatic chk(input string name, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void add_sat(
    input longint a, input longint e, input int w, input bit s,
    output longint r, output bit o
  );
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -(longint'(1) << (w - 1));
    longint t  = a + e;
    o = (t > mx) || (t < mn);
    if (!o) r = t;
    else if (s) r = (t > mx) ? mx : mn;
    else begin
      r = t & ((longint'(1) << w) - 1);
      if (r > mx) r = r - (longint'(1) << w);
    end
  endfunction

  task automatic model_reset(input bit wipe_lut);
    if (wipe_lut) foreach (lut_m[i]) lut_m[i] = 0;
    exp_q.delete();
    pend = 0; s1_occ = 0; row_pos = 0; row_len = 1;
    for (int j = 0; j < 3; j++) begin acc[j] = 0; flg[j] = 0; end
  endtask

  // one clock: check outputs, advance model, take the edge
  task automatic cycle();
    res_t   r;
    longint e;
    bit     o;
    int     idx;
    chk("in_ready", bm.in_ready,
        longint'((exp_q.size() + int'(pend)) < OD));
    chk("out_valid", bm.out_valid, longint'(exp_q.size() > 0));
    chk("out_valid_s", bs.out_valid, longint'(exp_q.size() > 0));
    chk("out_valid_w", bw.out_valid, longint'(exp_q.size() > 0));
    chk("busy", busy_m, longint'((row_pos != 0) || s1_occ));
    if (bm.out_valid && bm.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pop: unexpected result %0d", bm.result);
      end else begin
        r = exp_q.pop_front();
        chk("result_m", bm.result, r.v[0]);
        chk("sat_m", bm.sat, longint'(r.f[0]));
        chk("result_s", bs.result, r.v[1]);
        chk("sat_s", bs.sat, longint'(r.f[1]));
        chk("result_w", bw.result, r.v[2]);
        chk("sat_w", bw.sat, longint'(r.f[2]));
      end
    end
    if (pend && !clear) exp_q.push_back(pend_r);
    pend = 0;
    s1_occ = 0;
    if (clear) begin
      row_pos = 0;
      for (int j = 0; j < 3; j++) begin acc[j] = 0; flg[j] = 0; end
    end else if (bm.in_valid && bm.in_ready) begin
      if (row_pos == 0) row_len = int'(c_last) + 1;
      idx = row_pos * K + int'(bm.k_addr);
      for (int j = 0; j < 3; j++) begin
        add_sat(acc[j], longint'(lut_m[idx]), aw[j], sm[j], e, o);
        acc[j] = e;
        flg[j] = flg[j] | o;
      end
      row_pos++;
      s1_occ = 1;
      if (row_pos == row_len) begin
        pend = 1;
        pend_r.v = acc;
        pend_r.f = flg;
        row_pos = 0;
        for (int j = 0; j < 3; j++) begin acc[j] = 0; flg[j] = 0; end
      end
    end
    if (we) lut_m[waddr] = int'(wdata);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bm.in_valid = 0; bm.k_addr = '0; bm.out_ready = 0;
    we = 0; waddr = '0; wdata = '0; clear = 0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bm.out_valid && n < 10) begin cycle(); n++; end
    chk(name, bm.out_valid, 1);
  endtask

  task automatic pop_one();
    bm.out_ready = 1; cycle(); bm.out_ready = 0;
  endtask

  task automatic lut_write(input int a, input int d);
    we = 1; waddr = TA'(a); wdata = DW'(d);
    cycle();
    we = 0;
  endtask

  task automatic beat(input int k);
    bm.in_valid = 1; bm.k_addr = KA'(k);
    cycle();
    bm.in_valid = 0;
  endtask

  initial begin
    int acc_n;
    int n;
    tbl[0] = '{3, '{1, 2, 3, 4}, 106};
    tbl[1] = '{0, '{5, 0, 0, 0}, 5};
    tbl[2] = '{1, '{15, 15, 0, 0}, 46};
    tbl[3] = '{3, '{0, 0, 0, 0}, 96};
    tbl[4] = '{2, '{7, 8, 9, 0}, 72};
    tbl[5] = '{3, '{15, 14, 13, 12}, 150};

    idle();
    c_last = '0;
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bm.out_valid, 0);
    chk("rst_result", bm.result, 0);
    chk("rst_sat", bm.sat, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_in_ready", bm.in_ready, 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // LUT[{c,k}] = c*16 + k, i.e. the flat address
    for (int a = 0; a < C*K; a++) lut_write(a, a);

    foreach (tbl[i]) begin
      c_last = CA'(tbl[i].clast);
      for (int b = 0; b <= tbl[i].clast; b++) beat(tbl[i].k[b]);
      chk("tbl_t1_valid", bm.out_valid, 0);
      cycle();
      chk("tbl_t2_valid", bm.out_valid, 1);
      chk("tbl_sum", bm.result, tbl[i].sum);
      chk("tbl_sat", bm.sat, 0);
      pop_one();
    end

    // back-to-back one-beat rows with the consumer always ready
    c_last = '0;
    bm.out_ready = 1;
    acc_n = 0; n = 0;
    while (acc_n < 16 && n < 100) begin
      bm.in_valid = 1; bm.k_addr = KA'(acc_n);
      if (bm.in_ready) acc_n++;
      cycle();
      n++;
    end
    chk("b2b_accepted", acc_n, 16);
    bm.in_valid = 0;
    repeat (4) cycle();
    bm.out_ready = 0;

    // back-pressure with a two-entry FIFO
    beat(1);
    beat(2);
    chk("bp_ready_low", bm.in_ready, 0);
    bm.in_valid = 1; bm.k_addr = 3;
    cycle();
    cycle();
    chk("bp_still_low", bm.in_ready, 0);
    bm.out_ready = 1;
    cycle();
    bm.out_ready = 0;
    chk("bp_ready_back", bm.in_ready, 1);
    cycle();
    bm.in_valid = 0;
    chk("bp_third_taken", bm.in_ready, 0);
    bm.out_ready = 1;
    repeat (5) cycle();
    bm.out_ready = 0;

    // clear mid-row, then a full row
    c_last = 3;
    beat(1);
    beat(2);
    clear = 1; bm.in_valid = 1; bm.k_addr = 3;
    cycle();
    clear = 0; bm.in_valid = 0;
    beat(4); beat(5); beat(6); beat(7);
    wait_valid("clr_valid");
    chk("clr_sum", bm.result, 118);
    pop_one();
    repeat (3) cycle();
    chk("clr_single", bm.out_valid, 0);

    // write and read of the same entry in one cycle
    lut_write(5, 3);
    c_last = '0;
    we = 1; waddr = 5; wdata = 7;
    beat(5);
    we = 0;
    wait_valid("wr_valid1");
    chk("wr_old", bm.result, 3);
    pop_one();
    beat(5);
    wait_valid("wr_valid2");
    chk("wr_new", bm.result, 7);
    pop_one();

    // overflow: 0x7000 + 0x7000
    lut_write(0, 'h7000);
    lut_write(16, 'h7000);
    c_last = 1;
    beat(0);
    beat(0);
    wait_valid("ovf_valid");
    chk("ovf_m", bm.result, 'hE000);
    chk("ovf_m_sat", bm.sat, 0);
    chk("ovf_s", bs.result, 'h7FFF);
    chk("ovf_s_sat", bs.sat, 1);
    chk("ovf_w", bw.result, -8192);
    chk("ovf_w_sat", bw.sat, 1);
    pop_one();

    // reset in the middle of a row
    c_last = 3;
    beat(1);
    beat(2);
    rst_n = 0;
    #2;
    chk("mrst_out_valid", bm.out_valid, 0);
    chk("mrst_result", bm.result, 0);
    chk("mrst_sat", bm.sat, 0);
    chk("mrst_busy", busy_m, 0);
    idle();
    model_reset(1);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      we = ($urandom_range(0, 9) < 3);
      waddr = TA'($urandom);
      wdata = DW'($urandom);
      bm.in_valid = ($urandom_range(0, 9) < 7);
      bm.k_addr = KA'($urandom);
      c_last = ($urandom_range(0, 9) == 0) ?
               CA'($urandom) : CA'($urandom_range(0, 5));
      clear = ($urandom_range(0, 49) == 0);
      bm.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    idle();
    bm.out_ready = 1;
    n = 0;
    while ((exp_q.size() > 0 || pend) && n < 50) begin
      cycle();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
